// File: rtl/mesi_isc_broad_sched.sv
// mesi_isc_broad_sched
//   Sequences broadcast requests out of the broadcast FIFO. For each head
//   entry it snoops every CPU except the originator, waits for all snoop
//   acks, grants the originator (EN_WR / EN_RD), waits for its ack and pops
//   the entry. One broadcast is in flight at a time.
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   broad_fifo_status_empty_i  show-ahead FIFO empty (head valid when low)
//   broad_addr_i / broad_type_i / broad_cpu_id_i / broad_id_i   head entry
//   cbus_ack_array_i           per-CPU command ack (bit k = CPU k)
//   broad_fifo_rd_o            one-cycle pop strobe
//   cbus_cmd_array_o           per-CPU command, CPU k at [(k+1)*W-1:k*W]
//   cbus_addr_o / cbus_id_o    address / id of the in-flight broadcast
//   busy_o                     high whenever the sequencer is not idle
//   timeout_err_o              sticky watchdog error
//
// Build option
//   MESI_ISC_BROAD_SCHED_TIMEOUT_EN : builds the SNOOP/GRANT watchdog;
//   without it timeout_err_o is tied low.
module mesi_isc_broad_sched #(
   parameter int CBUS_CMD_WIDTH   = 3,
   parameter int ADDR_WIDTH       = 32,
   parameter int BROAD_TYPE_WIDTH = 2,
   parameter int BROAD_ID_WIDTH   = 7,
   parameter int TIMEOUT_CYCLES   = 255
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        broad_fifo_status_empty_i,
   input  logic [ADDR_WIDTH-1:0]       broad_addr_i,
   input  logic [BROAD_TYPE_WIDTH-1:0] broad_type_i,
   input  logic [1:0]                  broad_cpu_id_i,
   input  logic [BROAD_ID_WIDTH-1:0]   broad_id_i,
   input  logic [3:0]                  cbus_ack_array_i,
   output logic                        broad_fifo_rd_o,
   output logic [4*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o,
   output logic [ADDR_WIDTH-1:0]       cbus_addr_o,
   output logic [BROAD_ID_WIDTH-1:0]   cbus_id_o,
   output logic                        busy_o,
   output logic                        timeout_err_o
);

   localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_WR = BROAD_TYPE_WIDTH'(1);
   localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_RD = BROAD_TYPE_WIDTH'(2);

   localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
   localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
   localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
   localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(4);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SNOOP,
      ST_GRANT,
      ST_POP
   } state_t;

   state_t                      state;
   logic [BROAD_TYPE_WIDTH-1:0] type_q;
   logic [1:0]                  cpu_q;
   logic [3:0]                  mask;

   logic [3:0] in_onehot;
   logic [3:0] orig_onehot;
   logic [3:0] mask_left;
   logic       ack_hit;
   logic       in_is_snoop;

   // Replicates one command onto every CPU lane selected in sel.
   function automatic logic [4*CBUS_CMD_WIDTH-1:0] spread(
      input logic [3:0]                sel,
      input logic [CBUS_CMD_WIDTH-1:0] cmd
   );
      logic [4*CBUS_CMD_WIDTH-1:0] v;
      v = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         if (sel[k]) v[k*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = cmd;
      end
      return v;
   endfunction

   always_comb begin
      in_onehot   = 4'b0001 << broad_cpu_id_i;
      orig_onehot = 4'b0001 << cpu_q;
      mask_left   = mask & ~cbus_ack_array_i;
      ack_hit     = |(mask & cbus_ack_array_i);
      in_is_snoop = (broad_type_i == TYPE_WR) || (broad_type_i == TYPE_RD);
   end

   // Commands are computed from next-state values so they are registered
   // and appear in the same cycle as the state they belong to.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= ST_IDLE;
         type_q           <= '0;
         cpu_q            <= '0;
         mask             <= '0;
         broad_fifo_rd_o  <= 1'b0;
         cbus_cmd_array_o <= '0;
         cbus_addr_o      <= '0;
         cbus_id_o        <= '0;
         busy_o           <= 1'b0;
      end else begin
         broad_fifo_rd_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!broad_fifo_status_empty_i) begin
                  type_q      <= broad_type_i;
                  cpu_q       <= broad_cpu_id_i;
                  cbus_addr_o <= broad_addr_i;
                  cbus_id_o   <= broad_id_i;
                  busy_o      <= 1'b1;
                  if (in_is_snoop) begin
                     state            <= ST_SNOOP;
                     mask             <= ~in_onehot;
                     cbus_cmd_array_o <= spread(~in_onehot,
                        (broad_type_i == TYPE_WR) ? CMD_WR_SNOOP : CMD_RD_SNOOP);
                  end else begin
                     // NOP entry: discard straight away
                     state            <= ST_POP;
                     mask             <= '0;
                     broad_fifo_rd_o  <= 1'b1;
                     cbus_cmd_array_o <= '0;
                  end
               end
            end
            ST_SNOOP: begin
               mask <= mask_left;
               if (mask_left == 4'b0000) begin
                  state            <= ST_GRANT;
                  cbus_cmd_array_o <= spread(orig_onehot,
                     (type_q == TYPE_WR) ? CMD_EN_WR : CMD_EN_RD);
               end else begin
                  cbus_cmd_array_o <= spread(mask_left,
                     (type_q == TYPE_WR) ? CMD_WR_SNOOP : CMD_RD_SNOOP);
               end
            end
            ST_GRANT: begin
               if (cbus_ack_array_i[cpu_q]) begin
                  state            <= ST_POP;
                  broad_fifo_rd_o  <= 1'b1;
                  cbus_cmd_array_o <= '0;
               end
            end
            ST_POP: begin
               state            <= ST_IDLE;
               busy_o           <= 1'b0;
               cbus_cmd_array_o <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef MESI_ISC_BROAD_SCHED_TIMEOUT_EN
   logic [7:0] to_cnt;
   logic       to_err;

   // Counts cycles without progress in SNOOP/GRANT; any bit-clearing ack or
   // state entry restarts it. Saturates so a stuck broadcast cannot wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt <= '0;
         to_err <= 1'b0;
      end else begin
         case (state)
            ST_SNOOP: begin
               if (ack_hit) begin
                  to_cnt <= '0;
               end else begin
                  if (to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
                  if (to_cnt == TO_LAST) to_err <= 1'b1;
               end
            end
            ST_GRANT: begin
               if (cbus_ack_array_i[cpu_q]) begin
                  to_cnt <= '0;
               end else begin
                  if (to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
                  if (to_cnt == TO_LAST) to_err <= 1'b1;
               end
            end
            default: to_cnt <= '0;
         endcase
      end
   end

   assign timeout_err_o = to_err;
`else
   logic unused_cfg;
   assign unused_cfg    = ^{TO_LAST, ack_hit};
   assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mesi_isc_broad_sched.sv
// tb_mesi_isc_broad_sched
//   Self-checking bench for mesi_isc_broad_sched. A small show-ahead FIFO
//   model feeds the DUT; every pushed entry also goes onto a scoreboard that
//   is popped and compared whenever the DUT strobes broad_fifo_rd_o.
//   Per-cycle command expectations come from constant tables.
module tb_mesi_isc_broad_sched;

   localparam int TO = 20;
`ifdef MESI_ISC_BROAD_SCHED_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        empty;
   logic [31:0] h_addr;
   logic [1:0]  h_type;
   logic [1:0]  h_cpu;
   logic [6:0]  h_id;
   logic [3:0]  ack;
   logic        rd;
   logic [11:0] cmd;
   logic [31:0] c_addr;
   logic [6:0]  c_id;
   logic        busy;
   logic        terr;

   mesi_isc_broad_sched #(
      .CBUS_CMD_WIDTH   (3),
      .ADDR_WIDTH       (32),
      .BROAD_TYPE_WIDTH (2),
      .BROAD_ID_WIDTH   (7),
      .TIMEOUT_CYCLES   (TO)
   ) dut (
      .clk                       (clk),
      .rst                       (rst),
      .broad_fifo_status_empty_i (empty),
      .broad_addr_i              (h_addr),
      .broad_type_i              (h_type),
      .broad_cpu_id_i            (h_cpu),
      .broad_id_i                (h_id),
      .cbus_ack_array_i          (ack),
      .broad_fifo_rd_o           (rd),
      .cbus_cmd_array_o          (cmd),
      .cbus_addr_o               (c_addr),
      .cbus_id_o                 (c_id),
      .busy_o                    (busy),
      .timeout_err_o             (terr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  typ;
      logic [1:0]  cpu;
      logic [6:0]  id;
   } ent_t;

   ent_t fifo_q[$];
   ent_t sb_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
   endtask

   function automatic logic [11:0] cm(input int c3, input int c2, input int c1, input int c0);
      return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
   endfunction

   task automatic drive_fifo();
      if (fifo_q.size() == 0) begin
         empty  = 1'b1;
         h_addr = '0;
         h_type = '0;
         h_cpu  = '0;
         h_id   = '0;
      end else begin
         empty  = 1'b0;
         h_addr = fifo_q[0].addr;
         h_type = fifo_q[0].typ;
         h_cpu  = fifo_q[0].cpu;
         h_id   = fifo_q[0].id;
      end
   endtask

   task automatic push_entry(input logic [31:0] a, input logic [1:0] t,
                             input logic [1:0] c, input logic [6:0] i);
      ent_t e;
      e.addr = a;
      e.typ  = t;
      e.cpu  = c;
      e.id   = i;
      fifo_q.push_back(e);
      sb_q.push_back(e);
      drive_fifo();
   endtask

   // Advances one clock and samples #1 after the edge. The FIFO model pops on
   // the edge that closes a cycle in which the strobe was high.
   task automatic tick();
      logic rd_now;
      ent_t e;
      rd_now = rd;
      @(posedge clk);
      #1;
      if (rd_now && fifo_q.size() != 0) begin
         void'(fifo_q.pop_front());
         drive_fifo();
      end
      if (rd) begin
         check("pop_fifo_nonempty", 64'(fifo_q.size() != 0), 64'd1);
         if (sb_q.size() == 0) begin
            check("pop_unexpected", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("pop_addr", 64'(c_addr), 64'(e.addr));
            check("pop_id", 64'(c_id), 64'(e.id));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // Staggered RD from CPU 0: per-cycle ack / expected command / strobe
   logic [3:0]  s2_ack [1:9];
   logic [11:0] s2_cmd [1:9];
   logic        s2_rd  [1:9];
   logic        s2_bsy [1:9];

   initial begin
      s2_ack = '{4'b1000, 4'b1001, 4'b1000, 4'b0010, 4'b0010, 4'b0100, 4'b0001, 4'b0000, 4'b0000};
      s2_cmd = '{cm(2,2,2,0), cm(0,2,2,0), cm(0,2,2,0), cm(0,2,2,0), cm(0,2,0,0),
                 cm(0,2,0,0), cm(0,0,0,4), cm(0,0,0,0), cm(0,0,0,0)};
      s2_rd  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
      s2_bsy = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
   end

   initial begin
      rst = 1'b0;
      ack = 4'b0000;
      drive_fifo();

      // ---- reset with FIFO non-empty, then WR from CPU 2 ----
      #1;
      push_entry(32'h1000_0040, 2'd1, 2'd2, 7'h05);
      tick();
      tick();
      check("rst_cmd", 64'(cmd), 64'd0);
      check("rst_rd", 64'(rd), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_addr", 64'(c_addr), 64'd0);
      check("rst_id", 64'(c_id), 64'd0);
      check("rst_err", 64'(terr), 64'd0);
      rst = 1'b1;
      tick();
      check("wr_snoop_cmd", 64'(cmd), 64'(cm(1,0,1,1)));
      check("wr_snoop_busy", 64'(busy), 64'd1);
      check("wr_addr", 64'(c_addr), 64'h1000_0040);
      ack = 4'b1011;
      tick();
      check("wr_grant_cmd", 64'(cmd), 64'(cm(0,3,0,0)));
      check("wr_grant_rd", 64'(rd), 64'd0);
      ack = 4'b0100;
      tick();
      check("wr_pop_rd", 64'(rd), 64'd1);
      check("wr_pop_cmd", 64'(cmd), 64'd0);
      ack = 4'b0000;
      tick();
      check("wr_idle_rd", 64'(rd), 64'd0);
      check("wr_idle_busy", 64'(busy), 64'd0);
      check("wr_idle_addr_hold", 64'(c_addr), 64'h1000_0040);

      // ---- RD from CPU 0 with staggered / held / originator acks ----
      push_entry(32'h2000_0080, 2'd2, 2'd0, 7'h09);
      for (int i = 1; i <= 9; i++) begin
         tick();
         check($sformatf("rd_cmd_c%0d", i), 64'(cmd), 64'(s2_cmd[i]));
         check($sformatf("rd_rd_c%0d", i), 64'(rd), 64'(s2_rd[i]));
         check($sformatf("rd_busy_c%0d", i), 64'(busy), 64'(s2_bsy[i]));
         ack = s2_ack[i];
      end

      // ---- NOP entry, acks during POP ignored ----
      push_entry(32'h3000_0000, 2'd0, 2'd1, 7'h11);
      tick();
      check("nop_rd", 64'(rd), 64'd1);
      check("nop_cmd", 64'(cmd), 64'd0);
      check("nop_busy", 64'(busy), 64'd1);
      ack = 4'b1111;
      tick();
      check("nop_rd_off", 64'(rd), 64'd0);
      check("nop_cmd_idle", 64'(cmd), 64'd0);
      check("nop_busy_off", 64'(busy), 64'd0);
      ack = 4'b0000;

      // ---- back-to-back WR (CPU 1) then RD (CPU 3), acks held high ----
      push_entry(32'h0000_A000, 2'd1, 2'd1, 7'h21);
      push_entry(32'h0000_B000, 2'd2, 2'd3, 7'h42);
      ack = 4'b1111;
      for (int i = 1; i <= 8; i++) begin
         logic [11:0] ec;
         tick();
         case (i)
            1: ec = cm(1,1,0,1);
            2: ec = cm(0,0,3,0);
            5: ec = cm(0,2,2,2);
            6: ec = cm(4,0,0,0);
            default: ec = '0;
         endcase
         check($sformatf("b2b_cmd_c%0d", i), 64'(cmd), 64'(ec));
         check($sformatf("b2b_rd_c%0d", i), 64'(rd), 64'((i == 3) || (i == 7)));
         if (i == 4) check("b2b_addr_hold", 64'(c_addr), 64'h0000_A000);
         if (i == 5) check("b2b_addr_new", 64'(c_addr), 64'h0000_B000);
         if (i == 5) check("b2b_id_new", 64'(c_id), 64'h42);
      end
      ack = 4'b0000;

      // ---- reset mid-SNOOP aborts without pop, entry re-sequenced ----
      push_entry(32'h5000_0010, 2'd1, 2'd3, 7'h33);
      tick();
      check("abort_snoop", 64'(cmd), 64'(cm(0,1,1,1)));
      tick();
      rst = 1'b0;
      #1;
      check("abort_cmd", 64'(cmd), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_addr", 64'(c_addr), 64'd0);
      tick();
      tick();
      check("abort_no_pop", 64'(rd), 64'd0);
      check("abort_fifo_kept", 64'(empty), 64'd0);
      rst = 1'b1;
      tick();
      check("resq_snoop", 64'(cmd), 64'(cm(0,1,1,1)));
      ack = 4'b0111;
      tick();
      check("resq_grant", 64'(cmd), 64'(cm(3,0,0,0)));
      ack = 4'b1000;
      tick();
      check("resq_pop", 64'(rd), 64'd1);
      ack = 4'b0000;
      tick();

      // ---- CPU 1 snoop left unacked: watchdog (when built) ----
      push_entry(32'h4000_0100, 2'd1, 2'd0, 7'h22);
      for (int i = 1; i <= 29; i++) begin
         tick();
         if (i == 10) check("to_wait_cmd", 64'(cmd), 64'(cm(0,0,1,0)));
         if (i == 21) check("to_err_before", 64'(terr), 64'd0);
         if (i == 22) check("to_err_set", 64'(terr), 64'(TO_EN));
         if (i == 26) check("to_grant_cmd", 64'(cmd), 64'(cm(0,0,0,3)));
         if (i == 27) check("to_pop_rd", 64'(rd), 64'd1);
         if (i == 29) check("to_err_sticky", 64'(terr), 64'(TO_EN));
         if (i == 29) check("to_idle_busy", 64'(busy), 64'd0);
         case (i)
            1:       ack = 4'b1100;
            25:      ack = 4'b0010;
            26:      ack = 4'b0001;
            default: ack = 4'b0000;
         endcase
      end

      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
